// File: rtl/stm_focus_gen.sv
// Single-focus STM phase generator: fetches one focus word, then streams one
// phase/intensity pair per transducer through a fixed-latency calculation pipe.
module stm_focus_gen #(
    parameter int DEPTH        = 249,
    parameter int COORD_W      = 18,
    parameter int TR_W         = 16,
    parameter int PHASE_W      = 8,
    parameter int IDX_W        = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int CALC_LATENCY = 84,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [IDX_W-1:0]    IDX,
    output logic [IDX_W-1:0]    FOCUS_ADDR,
    input  logic [63:0]         FOCUS_DATA,
    output logic [CNT_W-1:0]    TR_ADDR,
    input  logic [2*TR_W-1:0]   TR_POS,
    input  logic [31:0]         SOUND_SPEED,
    input  logic [PHASE_W-1:0]  PHASE_OFFSET,
    input  logic [CNT_W-1:0]    NUM_TRANS,
    output logic [7:0]          INTENSITY,
    output logic [PHASE_W-1:0]  PHASE,
    output logic [CNT_W-1:0]    TR_IDX,
    output logic                DOUT_VALID,
    output logic                BUSY,
    output logic                DONE
);
    localparam int D2_W   = 2 * (COORD_W + 1) + 2;
    localparam int DIST_W = D2_W / 2;
    localparam int FRAC   = 18;
    localparam int FD_W   = 3 * COORD_W + 8;
    localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int PH_DLY = CALC_LATENCY - 3;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_ISSUE, S_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [WAIT_W-1:0]           wait_cnt_q;
    logic [CNT_W-1:0]            issue_cnt_q, n_q, n_clamp;
    logic [IDX_W-1:0]            idx_q;
    logic [31:0]                 ss_q;
    logic [PHASE_W-1:0]          off_q;
    logic signed [COORD_W-1:0]   fx_q, fy_q, fz_q;
    logic [7:0]                  inten_q;
    logic                        busy_q, done_q;
    logic                        issue_en, issue_last, zero_done, drain_done, pipe_last_out;

    // Per-transducer tag pipe: valid, index and end-of-pattern marker.
    logic                        vld_sr  [CALC_LATENCY];
    logic                        last_sr [CALC_LATENCY];
    logic [CNT_W-1:0]            idx_sr  [CALC_LATENCY];

    logic signed [COORD_W:0]     dx_c, dy_c, dx_q, dy_q;
    logic signed [D2_W-1:0]      dxe, dye, dze;
    logic [D2_W-1:0]             d2_q;
    logic [DIST_W-1:0]           dist_q;
    logic [63:0]                 num_c, quo_c;
    logic [PHASE_W-1:0]          phase_c;
    logic [PHASE_W-1:0]          ph_d [PH_DLY];
    logic [PHASE_W-1:0]          phase_q;
    logic [CNT_W-1:0]            tr_idx_q;
    logic [7:0]                  inten_out_q;
    logic                        dout_valid_q;
    logic                        unused_bits;

    function automatic logic [DIST_W-1:0] isqrt(input logic [D2_W-1:0] v);
        logic [D2_W-1:0] num, res, b;
        num = v;
        res = '0;
        b   = D2_W'(1) << (D2_W - 2);
        for (int i = 0; i < DIST_W; i++) begin
            if (num >= res + b) begin
                num = num - (res + b);
                res = (res >> 1) + b;
            end else begin
                res = res >> 1;
            end
            b = b >> 2;
        end
        return res[DIST_W-1:0];
    endfunction

    assign n_clamp       = (NUM_TRANS > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : NUM_TRANS;
    assign pipe_last_out = vld_sr[CALC_LATENCY-1] & last_sr[CALC_LATENCY-1];

    // START always wins: from IDLE it begins a pattern, otherwise it aborts and restarts.
    always_comb begin
        state_d    = state_q;
        issue_en   = 1'b0;
        issue_last = 1'b0;
        zero_done  = 1'b0;
        drain_done = 1'b0;
        if (START) begin
            state_d = S_WAIT;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_WAIT:  if (wait_cnt_q == WAIT_W'(MEM_LATENCY - 1)) state_d = S_LOAD;
                S_LOAD: begin
                    if (n_q == '0) begin
                        zero_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    issue_en = 1'b1;
                    if (issue_cnt_q == n_q - CNT_W'(1)) begin
                        issue_last = 1'b1;
                        state_d    = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pipe_last_out) begin
                        drain_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            issue_cnt_q <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            ss_q        <= '0;
            off_q       <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            fz_q        <= '0;
            inten_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= zero_done | drain_done;
            if (START) begin
                idx_q      <= IDX;
                ss_q       <= SOUND_SPEED;
                off_q      <= PHASE_OFFSET;
                n_q        <= n_clamp;
                wait_cnt_q <= '0;
                busy_q     <= 1'b1;
            end else begin
                if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                if (zero_done | drain_done) busy_q <= 1'b0;
                if (state_q == S_LOAD) begin
                    fx_q        <= FOCUS_DATA[COORD_W-1:0];
                    fy_q        <= FOCUS_DATA[2*COORD_W-1:COORD_W];
                    fz_q        <= FOCUS_DATA[3*COORD_W-1:2*COORD_W];
                    inten_q     <= FOCUS_DATA[FD_W-1:3*COORD_W];
                    issue_cnt_q <= '0;
                end
                if (issue_en) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
        end
    end

    // Arithmetic stages: diff at issue, d2 (+1), sqrt (+2), divide/offset (+3), then delay.
    assign dx_c = (COORD_W + 1)'(fx_q) - $signed({{(COORD_W + 1 - TR_W){1'b0}}, TR_POS[2*TR_W-1:TR_W]});
    assign dy_c = (COORD_W + 1)'(fy_q) - $signed({{(COORD_W + 1 - TR_W){1'b0}}, TR_POS[TR_W-1:0]});
    assign dxe  = D2_W'(dx_q);
    assign dye  = D2_W'(dy_q);
    assign dze  = D2_W'(fz_q);

    always_comb begin
        num_c   = 64'({dist_q, {FRAC{1'b0}}});
        quo_c   = (ss_q == '0) ? '1 : num_c / {32'b0, ss_q};
        phase_c = quo_c[PHASE_W-1:0] + off_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CALC_LATENCY; i++) begin
                vld_sr[i]  <= 1'b0;
                last_sr[i] <= 1'b0;
                idx_sr[i]  <= '0;
            end
            for (int i = 0; i < PH_DLY; i++) ph_d[i] <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            d2_q         <= '0;
            dist_q       <= '0;
            phase_q      <= '0;
            tr_idx_q     <= '0;
            inten_out_q  <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            vld_sr[0]  <= issue_en;
            last_sr[0] <= issue_last;
            idx_sr[0]  <= issue_cnt_q;
            for (int i = 1; i < CALC_LATENCY; i++) begin
                vld_sr[i]  <= START ? 1'b0 : vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
                idx_sr[i]  <= idx_sr[i-1];
            end
            dx_q    <= dx_c;
            dy_q    <= dy_c;
            d2_q    <= $unsigned(dxe * dxe + dye * dye + dze * dze);
            dist_q  <= isqrt(d2_q);
            ph_d[0] <= phase_c;
            for (int i = 1; i < PH_DLY; i++) ph_d[i] <= ph_d[i-1];
            dout_valid_q <= !START && vld_sr[CALC_LATENCY-1];
            if (!START && vld_sr[CALC_LATENCY-1]) begin
                phase_q     <= ph_d[PH_DLY-1];
                tr_idx_q    <= idx_sr[CALC_LATENCY-1];
                inten_out_q <= inten_q;
            end
        end
    end

    // DOUT_VALID qualifies PHASE/INTENSITY/TR_IDX for one cycle; there is no backpressure.
    assign FOCUS_ADDR  = idx_q;
    assign TR_ADDR     = issue_cnt_q;
    assign INTENSITY   = inten_out_q;
    assign PHASE       = phase_q;
    assign TR_IDX      = tr_idx_q;
    assign DOUT_VALID  = dout_valid_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign unused_bits = ^{quo_c[63:PHASE_W], FOCUS_DATA[63:FD_W]};

endmodule

// File: tb/tb_stm_focus_gen.sv
// Bench for stm_focus_gen: table vectors with hand-derived phases plus random
// patterns scored cycle-exactly against an arithmetic reference model.
module tb_stm_focus_gen;
    localparam int DEPTH = 249;
    localparam int COORD_W = 18;
    localparam int TR_W = 16;
    localparam int PHASE_W = 8;
    localparam int IDX_W = 16;
    localparam int ML = 2;
    localparam int CL = 84;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT = ML + 2 + CL;
    localparam int EW = 57;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [IDX_W-1:0]    idx = '0;
    logic [IDX_W-1:0]    focus_addr;
    logic [63:0]         focus_data;
    logic [CNT_W-1:0]    tr_addr;
    logic [2*TR_W-1:0]   tr_pos;
    logic [31:0]         sound_speed = '0;
    logic [PHASE_W-1:0]  phase_offset = '0;
    logic [CNT_W-1:0]    num_trans = '0;
    logic [7:0]          intensity;
    logic [PHASE_W-1:0]  phase;
    logic [CNT_W-1:0]    tr_idx;
    logic                dout_valid, busy, done;

    logic [63:0] focus_mem [0:63];
    int          fx_m [64];
    int          fy_m [64];
    int          fz_m [64];
    int          in_m [64];
    logic [31:0] tr_tab [0:255];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Scoreboard entry: {cycle[56:25], done[24], idx[23:16], intensity[15:8], phase[7:0]}
    logic [EW-1:0] exp_q[$];
    int            lone_q[$];
    logic [EW-1:0] mon_e, mon_g;

    typedef struct {
        int fx, fy, fz, inten, tx, ty;
        logic [31:0] ss;
        int off, exp_phase;
    } vec_t;
    vec_t vecs[6];

    stm_focus_gen #(
        .DEPTH(DEPTH), .COORD_W(COORD_W), .TR_W(TR_W), .PHASE_W(PHASE_W),
        .IDX_W(IDX_W), .MEM_LATENCY(ML), .CALC_LATENCY(CL)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .IDX(idx),
        .FOCUS_ADDR(focus_addr), .FOCUS_DATA(focus_data),
        .TR_ADDR(tr_addr), .TR_POS(tr_pos),
        .SOUND_SPEED(sound_speed), .PHASE_OFFSET(phase_offset), .NUM_TRANS(num_trans),
        .INTENSITY(intensity), .PHASE(phase), .TR_IDX(tr_idx),
        .DOUT_VALID(dout_valid), .BUSY(busy), .DONE(done)
    );

    assign focus_data = focus_mem[focus_addr[5:0]];
    assign tr_pos     = tr_tab[tr_addr];

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_phase(input int fx, input int fy, input int fz,
                                               input int tx, input int ty,
                                               input logic [31:0] ss, input int off);
        longint dx, dy, d2, r;
        logic [63:0] quo;
        dx = longint'(fx) - longint'(tx);
        dy = longint'(fy) - longint'(ty);
        d2 = dx * dx + dy * dy + longint'(fz) * longint'(fz);
        r  = longint'($sqrt(real'(d2)));
        while (r * r > d2) r--;
        while ((r + 1) * (r + 1) <= d2) r++;
        if (ss == 0) quo = '1;
        else quo = 64'((r * 262144) / longint'({32'b0, ss}));
        return 8'(quo + 64'(off));
    endfunction

    function automatic int rand_coord();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic set_focus(input int slot, input int fx, input int fy, input int fz, input int inten);
        fx_m[slot] = fx;
        fy_m[slot] = fy;
        fz_m[slot] = fz;
        in_m[slot] = inten;
        focus_mem[slot] = {2'b00, 8'(inten), 18'(fz), 18'(fy), 18'(fx)};
    endtask

    // Driver: pulse START, then build the expected stream (fixed_phase < 0 uses the model).
    task automatic start_pat(input int slot, input logic [31:0] ss, input int off,
                             input int n_raw, input int fixed_phase);
        int s, n;
        logic [7:0] ph;
        @(posedge clk); #1;
        start        = 1'b1;
        idx          = IDX_W'(slot);
        sound_speed  = ss;
        phase_offset = 8'(off);
        num_trans    = CNT_W'(n_raw);
        s = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.delete();
        lone_q.delete();
        n = (n_raw > DEPTH) ? DEPTH : n_raw;
        if (n == 0) lone_q.push_back(s + ML + 1);
        for (int k = 0; k < n; k++) begin
            if (fixed_phase >= 0) ph = 8'(fixed_phase);
            else ph = model_phase(fx_m[slot], fy_m[slot], fz_m[slot],
                                  int'(tr_tab[k][31:16]), int'(tr_tab[k][15:0]), ss, off);
            exp_q.push_back({32'(s + LAT + k), 1'(k == n - 1), 8'(k), 8'(in_m[slot]), ph});
        end
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("focus_addr", 64'(focus_addr), 64'(slot));
        sound_speed  = $urandom;
        phase_offset = 8'($urandom);
        num_trans    = CNT_W'($urandom);
        idx          = IDX_W'($urandom_range(0, 63));
    endtask

    task automatic wait_idle(input int maxc);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < maxc && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        @(posedge clk); #1;
        chk("pattern_finished", 64'(idle), 64'(1));
        chk("stream_drained", 64'(exp_q.size() + lone_q.size()), 64'(0));
        chk("busy_low_idle", 64'(busy), 64'(0));
    endtask

    task automatic run_vec(input int i);
        tr_tab[0] = {16'(vecs[i].tx), 16'(vecs[i].ty)};
        set_focus(i, vecs[i].fx, vecs[i].fy, vecs[i].fz, vecs[i].inten);
        start_pat(i, vecs[i].ss, vecs[i].off, 1, vecs[i].exp_phase);
        wait_idle(200);
    endtask

    // Scoreboard monitor: every output and every DONE must land on its expected cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_g = {32'(cyc), done, tr_idx, intensity, phase};
            while (exp_q.size() > 0 && int'(exp_q[0][56:25]) < cyc) begin
                checks++;
                failures++;
                $display("FAIL out_missing exp_cyc=%0d idx=%0d now=%0d", exp_q[0][56:25], exp_q[0][23:16], cyc);
                void'(exp_q.pop_front());
            end
            while (lone_q.size() > 0 && lone_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL done_missing exp_cyc=%0d now=%0d", lone_q[0], cyc);
                void'(lone_q.pop_front());
            end
            if (dout_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected cyc=%0d idx=%0d ph=%0d done=%0b", cyc, tr_idx, phase, done);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_g !== mon_e) begin
                        failures++;
                        $display("FAIL out_data got(cyc=%0d done=%0b idx=%0d int=%0h ph=%0d) exp(cyc=%0d done=%0b idx=%0d int=%0h ph=%0d)",
                                 mon_g[56:25], mon_g[24], mon_g[23:16], mon_g[15:8], mon_g[7:0],
                                 mon_e[56:25], mon_e[24], mon_e[23:16], mon_e[15:8], mon_e[7:0]);
                    end
                end
            end else if (done) begin
                checks++;
                if (lone_q.size() > 0 && lone_q[0] == cyc) void'(lone_q.pop_front());
                else begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{0, 0, 100, 'hA5, 0, 0, 32'd65536, 0, 144};
        vecs[1] = '{-3, 4, 0, 'h11, 0, 0, 32'd4096, 'hF0, 48};
        vecs[2] = '{5, 5, 5, 'h3C, 0, 0, 32'd0, 1, 0};
        vecs[3] = '{3, 4, 12, 'h7E, 0, 0, 32'd262144, 0, 13};
        vecs[4] = '{10, 0, 0, 'h01, 13, 4, 32'd1, 7, 7};
        vecs[5] = '{0, 0, 0, 'hFF, 2, 1, 32'd65536, 252, 4};
        for (int i = 0; i < 64; i++) set_focus(i, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) tr_tab[i] = '0;

        // Reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_dout_valid", 64'(dout_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_phase", 64'(phase), 64'(0));
        chk("rst_tr_idx", 64'(tr_idx), 64'(0));
        chk("rst_intensity", 64'(intensity), 64'(0));
        chk("rst_focus_addr", 64'(focus_addr), 64'(0));
        chk("rst_tr_addr", 64'(tr_addr), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors: single focus, signed coords/offset, SOUND_SPEED=0, misc
        for (int i = 0; i < 6; i++) run_vec(i);

        // Full streaming with a random position table, then a clamped count
        for (int k = 0; k < 256; k++) tr_tab[k] = $urandom;
        set_focus(20, rand_coord(), rand_coord(), rand_coord(), int'($urandom_range(0, 255)));
        start_pat(20, $urandom_range(1, 1 << 22), int'($urandom_range(0, 255)), 249, -1);
        wait_idle(400);
        set_focus(21, rand_coord(), rand_coord(), rand_coord(), int'($urandom_range(0, 255)));
        start_pat(21, $urandom_range(1, 1 << 16), int'($urandom_range(0, 255)), 255, -1);
        wait_idle(400);

        // Zero transducers: lone DONE one cycle after LOAD
        start_pat(5, 32'd100, 3, 0, -1);
        wait_idle(20);

        // Restart while busy: early (pipe filling) and late (outputs streaming)
        for (int k = 0; k < 256; k++) tr_tab[k] = $urandom;
        for (int s = 30; s < 33; s++)
            set_focus(s, rand_coord(), rand_coord(), rand_coord(), int'($urandom_range(0, 255)));
        start_pat(30, $urandom_range(1, 1 << 20), int'($urandom_range(0, 255)), 249, -1);
        repeat (50) @(posedge clk);
        start_pat(31, $urandom_range(1, 1 << 20), int'($urandom_range(0, 255)), 249, -1);
        repeat (130) @(posedge clk);
        start_pat(32, $urandom_range(1, 1 << 20), int'($urandom_range(0, 255)), 249, -1);
        wait_idle(400);

        // Short random patterns, first with SOUND_SPEED=0
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 32; k++) tr_tab[k] = $urandom;
            set_focus(40 + r, rand_coord(), rand_coord(), rand_coord(), int'($urandom_range(0, 255)));
            start_pat(40 + r, (r == 0) ? 32'd0 : 32'($urandom_range(1, 1 << 22)),
                      int'($urandom_range(0, 255)), int'($urandom_range(1, 30)), -1);
            wait_idle(200);
        end

        // Reset mid-stream, then a clean single-focus run
        for (int k = 0; k < 256; k++) tr_tab[k] = $urandom;
        set_focus(50, rand_coord(), rand_coord(), rand_coord(), int'($urandom_range(0, 255)));
        start_pat(50, $urandom_range(1, 1 << 20), int'($urandom_range(0, 255)), 249, -1);
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_dout_valid", 64'(dout_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        exp_q.delete();
        lone_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(0);

        repeat (5) @(posedge clk);
        chk("final_queue_empty", 64'(exp_q.size() + lone_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
